// File: rtl/mem_init_engine_if.sv
// Purpose: bus bundle between the memory-init engine and its environment.
//   slave  : engine side (erase request, ioctl download, CPU port in; RAM port and status out)
//   master : environment side (drives requests, observes RAM port and status)
interface mem_init_engine_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  // control inputs to the engine
  logic              ext_reset;
  logic              erase_req;
  // HPS ioctl download port
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [DATA_W-1:0] ioctl_dout;
  // CPU port
  logic [ADDR_W-1:0] cpu_a;
  logic              cpu_we_n;
  logic [DATA_W-1:0] cpu_d;
  // RAM port
  logic [ADDR_W-1:0] mem_a;
  logic              mem_we;
  logic [DATA_W-1:0] mem_d;
  // status
  logic              busy;
  logic              erase_done;
  logic              sys_reset;

  modport slave (
    input  ext_reset, erase_req,
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  cpu_a, cpu_we_n, cpu_d,
    output mem_a, mem_we, mem_d,
    output busy, erase_done, sys_reset
  );

  modport master (
    output ext_reset, erase_req,
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output cpu_a, cpu_we_n, cpu_d,
    input  mem_a, mem_we, mem_d,
    input  busy, erase_done, sys_reset
  );
endinterface

// File: rtl/mem_init_engine.sv
// Purpose: memory-initialisation front end for the main RAM port. Arbitrates
//   a region erase engine, ioctl download writes and CPU accesses (priority in
//   that order) and generates the stretched console reset.
// Ports:
//   clk_sys  - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - mem_init_engine_if.slave: ext_reset, erase_req, ioctl_*, cpu_*
//              in; mem_a/mem_we/mem_d, busy, erase_done, sys_reset out
module mem_init_engine #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 8,
  parameter logic [ADDR_W-1:0] ERASE_START = ADDR_W'('h7000),
  parameter logic [ADDR_W-1:0] ERASE_END   = ADDR_W'('hFFFF),
  parameter logic [DATA_W-1:0] FILL        = '0,
  parameter logic [ADDR_W-1:0] BASE0       = ADDR_W'('h0000),
  parameter logic [ADDR_W-1:0] BASE1       = ADDR_W'('hC000),
  parameter int unsigned       RESET_HOLD  = 255
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  mem_init_engine_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(RESET_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ea;
  logic              r_busy;
  logic              r_done;
  logic              r_req_q;

  logic              r_dl_wr;
  logic [ADDR_W-1:0] r_dl_a;
  logic [DATA_W-1:0] r_dl_d;

  logic [CNT_W-1:0]  r_cnt;

  logic              w_rise;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_dl_a;
  logic              w_hold;

  // Only the low ADDR_W bits of the download address reach the RAM.
  if (ADDR_W < 25) begin : g_addr_unused
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^bus.ioctl_addr[24:ADDR_W];
  end

  assign w_rise = bus.erase_req & ~r_req_q;

  // Erase FSM. The end compare happens before the increment so an erase that
  // ends at the top address never wraps back to zero.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ea    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req_q <= 1'b0;
    end else begin
      r_req_q <= bus.erase_req;
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          // A rise during a download is dropped, not deferred.
          if (w_rise && !bus.ioctl_download) begin
            r_state <= ST_ERASE;
            r_ea    <= ERASE_START;
            r_busy  <= 1'b1;
          end
        end
        ST_ERASE: begin
          if (bus.ioctl_download) begin
            // Download takes over: abandon the erase without a done pulse.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_ea == ERASE_END) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_ea <= r_ea + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Download stage: slot 0 and the other slots map to separate base offsets.
  assign w_base = (bus.ioctl_index == 8'd0) ? BASE0 : BASE1;
  assign w_dl_a = bus.ioctl_addr[ADDR_W-1:0] + w_base;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_wr <= 1'b0;
      r_dl_a  <= '0;
      r_dl_d  <= '0;
    end else begin
      r_dl_wr <= bus.ioctl_wr;
      r_dl_a  <= w_dl_a;
      r_dl_d  <= bus.ioctl_dout;
    end
  end

  // Reset stretch: reload while any source is active, then count down.
  assign w_hold = bus.ext_reset | bus.ioctl_download | r_busy;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= CNT_W'(RESET_HOLD);
    end else if (w_hold) begin
      r_cnt <= CNT_W'(RESET_HOLD);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // RAM port mux over registered sources; CPU writes are suppressed while the
  // engine is busy (including the DONE cycle).
  always_comb begin
    bus.mem_a  = bus.cpu_a;
    bus.mem_d  = bus.cpu_d;
    bus.mem_we = ~bus.cpu_we_n;
    if (r_state == ST_ERASE) begin
      bus.mem_a  = r_ea;
      bus.mem_d  = FILL;
      bus.mem_we = 1'b1;
    end else if (bus.ioctl_download) begin
      bus.mem_a  = r_dl_a;
      bus.mem_d  = r_dl_d;
      bus.mem_we = r_dl_wr;
    end else if (r_busy) begin
      bus.mem_we = 1'b0;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.erase_done = r_done;
  assign bus.sys_reset  = w_hold | (r_cnt != '0);

endmodule

// File: tb/tb_mem_init_engine.sv
// Scoreboard bench for mem_init_engine: expected RAM writes are queued when
// stimulus is driven and popped by a negedge monitor as writes appear.
module tb_mem_init_engine;

  logic clk_sys;
  logic reset_n;

  mem_init_engine_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_init_engine dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  done_cnt = 0;

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Monitor: every RAM write must match the head of the scoreboard.
  always @(negedge clk_sys) begin
    if (bus.erase_done === 1'b1) done_cnt++;
    if (bus.mem_we !== 1'b0) begin
      if (sb.size() == 0) begin
        check("spurious_we", 64'(bus.mem_we), 64'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr", 64'({bus.mem_a, bus.mem_d}), 64'({e.a, e.d}));
      end
    end
  end

  initial begin
    int n;
    bus.ext_reset      = 1'b0;
    bus.erase_req      = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 25'd0;
    bus.ioctl_dout     = 8'd0;
    bus.cpu_a          = 16'd0;
    bus.cpu_we_n       = 1'b1;
    bus.cpu_d          = 8'd0;
    reset_n            = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_sys);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.erase_done), 64'd0);
    check("rst_sysrst", 64'(bus.sys_reset), 64'd1);
    check("rst_we", 64'(bus.mem_we), 64'd0);
    tick();
    reset_n = 1'b1;

    // Power-on stretch must expire
    n = 0;
    while (bus.sys_reset && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    check("por_release", 64'(bus.sys_reset), 64'd0);

    // CPU write while idle appears in the same cycle
    tick();
    bus.cpu_a    = 16'h1234;
    bus.cpu_d    = 8'h5A;
    bus.cpu_we_n = 1'b0;
    push_wr(16'h1234, 8'h5A);
    #1;
    check("cpu_a", 64'(bus.mem_a), 64'h1234);
    check("cpu_we", 64'(bus.mem_we), 64'd1);
    tick();
    bus.cpu_we_n = 1'b1;

    // ext_reset pulse of one cycle: sys_reset high 256 cycles total
    tick();
    bus.ext_reset = 1'b1;
    @(negedge clk_sys);
    n = bus.sys_reset ? 1 : 0;
    tick();
    bus.ext_reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_sys);
      if (!bus.sys_reset) break;
      n++;
    end
    check("rst_stretch", 64'(n), 64'd256);
    check("rst_stretch_end", 64'(bus.sys_reset), 64'd0);

    // Download: slot 1 uses BASE1, slot 0 uses BASE0, one-cycle latency
    tick();
    bus.ioctl_download = 1'b1;
    bus.ioctl_wr       = 1'b1;
    bus.ioctl_index    = 8'd1;
    bus.ioctl_addr     = 25'h10;
    bus.ioctl_dout     = 8'hAA;
    push_wr(16'hC010, 8'hAA);
    #1;
    check("dl_latency", 64'(bus.mem_we), 64'd0);
    tick();
    bus.ioctl_index = 8'd0;
    bus.ioctl_dout  = 8'h55;
    push_wr(16'h0010, 8'h55);
    tick();
    bus.ioctl_wr  = 1'b0;
    bus.erase_req = 1'b1;
    tick();
    bus.erase_req = 1'b0;
    check("dl_sysrst", 64'(bus.sys_reset), 64'd1);
    tick();
    bus.ioctl_download = 1'b0;
    repeat (5) tick();
    check("dl_erase_ignored", 64'(bus.busy), 64'd0);

    // Full erase 7000..FFFF
    for (int a = 'h7000; a <= 'hFFFF; a++) push_wr(16'(a), 8'h00);
    tick();
    bus.erase_req = 1'b1;
    tick();
    bus.erase_req = 1'b0;
    check("er_busy", 64'(bus.busy), 64'd1);
    n = 1;
    while (n < 40000) begin
      @(negedge clk_sys);
      if (bus.erase_done) break;
      n++;
    end
    check("er_done_lat", 64'(n), 64'd36865);
    check("er_done_busy", 64'(bus.busy), 64'd1);
    check("er_sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk_sys);
    check("er_busy_drop", 64'(bus.busy), 64'd0);
    check("er_done_pulse", 64'(bus.erase_done), 64'd0);
    check("er_done_cnt", 64'(done_cnt), 64'd1);

    // Erase aborted by download at ea=8000; CPU writes suppressed while busy
    for (int a = 'h7000; a <= 'h8000; a++) push_wr(16'(a), 8'h00);
    tick();
    bus.erase_req = 1'b1;
    tick();
    bus.erase_req = 1'b0;
    repeat (9) tick();
    bus.cpu_a    = 16'h1234;
    bus.cpu_d    = 8'h5A;
    bus.cpu_we_n = 1'b0;
    repeat (5) tick();
    bus.cpu_we_n = 1'b1;
    repeat ('h1000 - 14) tick();
    bus.ioctl_download = 1'b1;
    #1;
    check("ab_addr", 64'(bus.mem_a), 64'h8000);
    tick();
    check("ab_busy", 64'(bus.busy), 64'd0);
    bus.ioctl_wr    = 1'b1;
    bus.ioctl_index = 8'd2;
    bus.ioctl_addr  = 25'h20;
    bus.ioctl_dout  = 8'h33;
    push_wr(16'hC020, 8'h33);
    tick();
    bus.ioctl_wr = 1'b0;
    tick();
    bus.ioctl_download = 1'b0;
    repeat (3) tick();
    check("ab_no_done", 64'(done_cnt), 64'd1);
    check("ab_sb_empty", 64'(sb.size()), 64'd0);

    // Async reset mid-erase
    for (int a = 'h7000; a < 'h7000 + 99; a++) push_wr(16'(a), 8'h00);
    tick();
    bus.erase_req = 1'b1;
    tick();
    bus.erase_req = 1'b0;
    repeat (99) tick();
    reset_n = 1'b0;
    #1;
    check("mr_busy", 64'(bus.busy), 64'd0);
    check("mr_sysrst", 64'(bus.sys_reset), 64'd1);
    check("mr_sb_empty", 64'(sb.size()), 64'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check("mr_no_resume", 64'(bus.busy), 64'd0);
    check("mr_done_cnt", 64'(done_cnt), 64'd1);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
